// File: rtl/enc_fxp_pkg.sv
// Sign-magnitude fixed-point constants and arithmetic shared by the encoder layers.
// Build option: define ENC_SATURATE_EN to clamp magnitude overflow instead of wrapping it.
package enc_fxp_pkg;

  localparam int BITSIZE  = 16;
  localparam int FRAC     = 10;
  localparam int SIGN_BIT = BITSIZE - 1;
  localparam int MAG_W    = BITSIZE - 1;
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  typedef logic [BITSIZE-1:0] sm_word_t;
  typedef logic [2*MAG_W-1:0] wide_mag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_BIAS,
    ST_DONE
  } layer_state_e;

  // Fold a wide intermediate magnitude back into the word's magnitude field.
  function automatic logic [MAG_W-1:0] mag_fit(input wide_mag_t wide);
`ifdef ENC_SATURATE_EN
    mag_fit = (|wide[2*MAG_W-1:MAG_W]) ? MAG_MAX : MAG_W'(wide);
`else
    mag_fit = MAG_W'(wide) & MAG_MAX;
`endif
  endfunction

  function automatic sm_word_t sm_make(input logic sign, input logic [MAG_W-1:0] mag);
    sm_make = (mag == '0) ? '0 : {sign, mag};
  endfunction

  function automatic sm_word_t sm_mul(input sm_word_t a, input sm_word_t b);
    wide_mag_t ma;
    wide_mag_t mb;
    wide_mag_t prod;
    ma   = wide_mag_t'(a[MAG_W-1:0]);
    mb   = wide_mag_t'(b[MAG_W-1:0]);
    prod = (ma * mb) >> FRAC;
    sm_mul = sm_make(a[SIGN_BIT] ^ b[SIGN_BIT], mag_fit(prod));
  endfunction

  // A zero magnitude carries no sign, so -0 never decides the result sign.
  function automatic sm_word_t sm_add(input sm_word_t a, input sm_word_t b);
    logic [MAG_W-1:0] ma;
    logic [MAG_W-1:0] mb;
    logic sa;
    logic sb;
    ma = a[MAG_W-1:0];
    mb = b[MAG_W-1:0];
    sa = a[SIGN_BIT] && (ma != '0);
    sb = b[SIGN_BIT] && (mb != '0);
    if (sa == sb)
      sm_add = sm_make(sa, mag_fit(wide_mag_t'(ma) + wide_mag_t'(mb)));
    else if (ma >= mb)
      sm_add = sm_make(sa, ma - mb);
    else
      sm_add = sm_make(sb, mb - ma);
  endfunction

endpackage

// File: rtl/enc_dense_layer_if.sv
// Operand/result bundle of the dense layer: flattened x, w, b vectors in and y out.
interface enc_dense_layer_if
  import enc_fxp_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_OUT = 6
) ();

  logic [BITSIZE*N_IN-1:0]       x;
  logic [BITSIZE*N_IN*N_OUT-1:0] w;
  logic [BITSIZE*N_OUT-1:0]      b;
  logic [BITSIZE*N_OUT-1:0]      y;

  modport master (output x, output w, output b, input y);
  modport slave  (input x, input w, input b, output y);

endinterface

// File: rtl/enc_sm_mac.sv
// One sign-magnitude multiply-accumulate lane; adds x*w into its accumulator when enabled.
module enc_sm_mac
  import enc_fxp_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     acc_en,
  input  sm_word_t x_in,
  input  sm_word_t w_in,
  output sm_word_t acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc <= '0;
    else if (acc_en)
      acc <= sm_add(acc, sm_mul(x_in, w_in));
  end

endmodule

// File: rtl/enc_dense_layer.sv
// Dense layer y[j] = b[j] + sum_i x[i]*w[j][i]; one input element per clock over N_OUT lanes.
// Releasing reset starts a pass; the result appears N_IN+1 edges later and holds until reset.
module enc_dense_layer
  import enc_fxp_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_OUT = 6
) (
  input logic         clk,
  input logic         reset,
  enc_dense_layer_if.slave bus
);

  localparam int CNT_W = $clog2(N_IN + 1);

  layer_state_e state;
  layer_state_e state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic acc_en;
  logic load_y;

  sm_word_t x_sel;
  sm_word_t w_sel [N_OUT];
  sm_word_t acc   [N_OUT];
  logic [N_OUT-1:0][BITSIZE-1:0] y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // IDLE already performs step 1, so the first edge after release accumulates x[0].
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_en     = 1'b0;
    load_y     = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        acc_en   = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (cnt_next == CNT_W'(N_IN))
          state_next = ST_BIAS;
        else
          state_next = ST_ACCUM;
      end
      ST_BIAS: begin
        load_y     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_IN; i++)
      if (cnt == CNT_W'(i))
        x_sel = bus.x[i*BITSIZE +: BITSIZE];
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_sel[j] = '0;
      for (int i = 0; i < N_IN; i++)
        if (cnt == CNT_W'(i))
          w_sel[j] = bus.w[(j*N_IN+i)*BITSIZE +: BITSIZE];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    enc_sm_mac u_mac (
      .clk    (clk),
      .reset  (reset),
      .acc_en (acc_en),
      .x_in   (x_sel),
      .w_in   (w_sel[j]),
      .acc    (acc[j])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      y_q <= '0;
    else if (load_y)
      for (int j = 0; j < N_OUT; j++)
        y_q[j] <= sm_add(acc[j], bus.b[j*BITSIZE +: BITSIZE]);
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_enc_dense_layer.sv
// Directed bench for enc_dense_layer: reset behaviour, latency, sign/zero rules, overflow, restart.
module tb_enc_dense_layer;
  import enc_fxp_pkg::*;

  localparam int N_IN  = 10;
  localparam int N_OUT = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  enc_dense_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  enc_dense_layer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  sm_word_t xs [N_IN];
  sm_word_t ws [N_OUT][N_IN];
  sm_word_t bs [N_OUT];
  sm_word_t exp_y [N_OUT];
  int total = 0;
  int bad   = 0;

  task automatic applyStimulus();
    for (int i = 0; i < N_IN; i++)
      bus.x[i*BITSIZE +: BITSIZE] = xs[i];
    for (int j = 0; j < N_OUT; j++) begin
      bus.b[j*BITSIZE +: BITSIZE] = bs[j];
      for (int i = 0; i < N_IN; i++)
        bus.w[(j*N_IN+i)*BITSIZE +: BITSIZE] = ws[j][i];
    end
  endtask

  task automatic fillUniform(input sm_word_t xv, input sm_word_t wv, input sm_word_t bv,
                             input sm_word_t ev);
    for (int i = 0; i < N_IN; i++) xs[i] = xv;
    for (int j = 0; j < N_OUT; j++) begin
      bs[j]    = bv;
      exp_y[j] = ev;
      for (int i = 0; i < N_IN; i++) ws[j][i] = wv;
    end
  endtask

  task automatic checkWord(input string tag, input sm_word_t obs, input sm_word_t expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkZero(input string tag);
    total++;
    assert (bus.y === '0)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed y=%h expected all zero", tag, bus.y);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int j = 0; j < N_OUT; j++)
      checkWord($sformatf("%s y[%0d]", tag, j), bus.y[j*BITSIZE +: BITSIZE], exp_y[j]);
  endtask

  // Release reset, expect zero through edge N_IN, the result at edge N_IN+1, then a hold.
  task automatic runLayer(input string tag);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      @(posedge clk);
      #1;
      checkZero($sformatf("%s early edge %0d", tag, k));
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " result"});
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, " hold"});
  endtask

  task automatic holdReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    reset = 1'b1;
    for (int i = 0; i < N_IN; i++) xs[i] = sm_word_t'($urandom);
    for (int j = 0; j < N_OUT; j++) begin
      bs[j] = sm_word_t'($urandom);
      for (int i = 0; i < N_IN; i++) ws[j][i] = sm_word_t'($urandom);
    end
    applyStimulus();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkZero($sformatf("t1 reset held %0d", k));
    end

    // 10 * (1.0 * 0.5) = 5.0
    fillUniform(16'h0400, 16'h0200, 16'h0000, 16'h1400);
    applyStimulus();
    runLayer("t2");

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkZero("t1 async clear");

    // 1.0 * -2.0 + 0.5 = -1.5
    fillUniform(16'h0000, 16'h0000, 16'h0200, 16'h8600);
    xs[0] = 16'h0400;
    for (int j = 0; j < N_OUT; j++) ws[j][0] = 16'h8800;
    applyStimulus();
    runLayer("t3");

    // 1.0 - 1.0 + (-0) must come out as +0
    holdReset();
    fillUniform(16'h0000, 16'h0000, 16'h8000, 16'h0000);
    xs[0] = 16'h0400;
    xs[1] = 16'h0400;
    for (int j = 0; j < N_OUT; j++) begin
      ws[j][0] = 16'h0400;
      ws[j][1] = 16'h8400;
    end
    applyStimulus();
    runLayer("t4");

    // 15*15 = 225 overflows each product; wrapped it leaves 1.0, ten of them give 10.0
    holdReset();
`ifdef ENC_SATURATE_EN
    fillUniform(16'h3C00, 16'h3C00, 16'h0000, 16'h7FFF);
`else
    fillUniform(16'h3C00, 16'h3C00, 16'h0000, 16'h2800);
`endif
    applyStimulus();
    runLayer("t5");

    // Off-diagonal selector: lane j picks x[j+2]; a distinct bias per lane
    holdReset();
    fillUniform(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < N_IN; i++) xs[i] = sm_word_t'((i + 1) * 256);
    for (int j = 0; j < N_OUT; j++) begin
      ws[j][j+2] = 16'h0400;
      bs[j]      = sm_word_t'(j);
      exp_y[j]   = sm_word_t'((j + 3) * 256 + j);
    end
    applyStimulus();
    runLayer("t7");

    // Abort after edge 5, then a clean restart must still give 5.0
    holdReset();
    fillUniform(16'h0400, 16'h0200, 16'h0000, 16'h1400);
    applyStimulus();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checkZero($sformatf("t6 partial edge %0d", k));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkZero("t6 abort");
    @(posedge clk);
    #1;
    checkZero("t6 abort hold");
    runLayer("t6 restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
